// File: rtl/float_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor, round-to-nearest-even.
// Denormals are flushed to zero. All registers update on the falling clock edge.
module float_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = EXP_W + MAN_W + 1
) (
  input  logic         MAIN_CLK,
  input  logic         MAIN_RST,
  input  logic         in_valid,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W-1:0] ab,
  output logic         ovf,
  output logic         unf,
  output logic         nan
);

  localparam int unsigned M_W  = MAN_W + 1;        // hidden bit + mantissa
  localparam int unsigned F_W  = MAN_W + 4;        // aligned field incl. guard/round/sticky
  localparam int unsigned S_W  = MAN_W + 5;        // sum incl. carry
  localparam int unsigned LZ_W = $clog2(S_W + 1);
  localparam int unsigned E_W  = EXP_W + 2;        // exponent with headroom and sign bit
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  // ---------------- stage 1: unpack, classify, order by magnitude ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb, ma_f, mb_f;
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;

  assign sa     = a[W-1];
  assign sb     = b[W-1] ^ op_sub;
  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign ma     = a[MAN_W-1:0];
  assign mb     = b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign ma_f   = a_zero ? '0 : ma;
  assign mb_f   = b_zero ? '0 : mb;
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign swap   = {eb, mb_f} > {ea, ma_f};

  logic             s1_valid, s1_sign, s1_sub, s1_nan, s1_inf, s1_inf_s;
  logic [EXP_W-1:0] s1_e, s1_d;
  logic [M_W-1:0]   s1_bm, s1_sm;

  // Register the ordered operands, exponent gap and special-case outcome
  always_ff @(negedge MAIN_CLK or posedge MAIN_RST) begin
    if (MAIN_RST) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_inf_s <= 1'b0;
      s1_e     <= '0;
      s1_d     <= '0;
      s1_bm    <= '0;
      s1_sm    <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sign  <= swap ? sb : sa;
      s1_sub   <= sa ^ sb;
      s1_nan   <= a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
      s1_inf   <= a_inf | b_inf;
      s1_inf_s <= a_inf ? sa : sb;
      s1_e     <= swap ? eb : ea;
      s1_d     <= swap ? (eb - ea) : (ea - eb);
      s1_bm    <= swap ? {~b_zero, mb_f} : {~a_zero, ma_f};
      s1_sm    <= swap ? {~a_zero, ma_f} : {~b_zero, mb_f};
    end
  end

  // ---------------- stage 2: align the smaller operand ----------------
  logic [F_W-1:0] ext, al;

  // Right shift with sticky collection; large gaps collapse to a lone sticky bit
  always_comb begin
    ext = {s1_sm, 3'b000};
    al  = '0;
    if (32'(s1_d) >= F_W - 1) begin
      al[0] = |s1_sm;
    end else begin
      al    = ext >> s1_d;
      al[0] = al[0] | (|(ext & ~({F_W{1'b1}} << s1_d)));
    end
  end

  logic             s2_valid, s2_sign, s2_sub, s2_nan, s2_inf, s2_inf_s;
  logic [EXP_W-1:0] s2_e;
  logic [F_W-1:0]   s2_bf, s2_sf;

  // Register aligned mantissas
  always_ff @(negedge MAIN_CLK or posedge MAIN_RST) begin
    if (MAIN_RST) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_sub   <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_inf_s <= 1'b0;
      s2_e     <= '0;
      s2_bf    <= '0;
      s2_sf    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_sub   <= s1_sub;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_inf_s <= s1_inf_s;
      s2_e     <= s1_e;
      s2_bf    <= {s1_bm, 3'b000};
      s2_sf    <= al;
    end
  end

  // ---------------- stage 3: add/subtract and count leading zeros ----------------
  logic [S_W-1:0]  sum;
  logic [LZ_W-1:0] lzc;
  logic            found;

  // Magnitude ordering guarantees the difference is non-negative
  always_comb begin
    sum   = s2_sub ? ({1'b0, s2_bf} - {1'b0, s2_sf}) : ({1'b0, s2_bf} + {1'b0, s2_sf});
    lzc   = LZ_W'(S_W);
    found = 1'b0;
    for (int i = S_W - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lzc   = LZ_W'(S_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  logic             s3_valid, s3_sign, s3_sub, s3_nan, s3_inf, s3_inf_s;
  logic [EXP_W-1:0] s3_e;
  logic [S_W-1:0]   s3_sum;
  logic [LZ_W-1:0]  s3_lzc;

  // Register raw sum and its leading-zero count
  always_ff @(negedge MAIN_CLK or posedge MAIN_RST) begin
    if (MAIN_RST) begin
      s3_valid <= 1'b0;
      s3_sign  <= 1'b0;
      s3_sub   <= 1'b0;
      s3_nan   <= 1'b0;
      s3_inf   <= 1'b0;
      s3_inf_s <= 1'b0;
      s3_e     <= '0;
      s3_sum   <= '0;
      s3_lzc   <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_sign  <= s2_sign;
      s3_sub   <= s2_sub;
      s3_nan   <= s2_nan;
      s3_inf   <= s2_inf;
      s3_inf_s <= s2_inf_s;
      s3_e     <= s2_e;
      s3_sum   <= sum;
      s3_lzc   <= lzc;
    end
  end

  // ---------------- stage 4: normalise, round, pack ----------------
  logic [S_W-1:0]   norm;
  logic [LZ_W-1:0]  sh;
  logic             carry, inc;
  logic [M_W:0]     rnd;
  logic [E_W-1:0]   e_n, e_r;
  logic [W-1:0]     r_ab;
  logic             r_ovf, r_unf, r_nan, unused_bits;

  // Leading one lands at bit S_W-2; then RNE on guard/round/sticky
  always_comb begin
    carry = s3_sum[S_W-1];
    sh    = '0;
    norm  = s3_sum;
    if (carry) begin
      norm    = s3_sum >> 1;
      norm[0] = s3_sum[1] | s3_sum[0];
    end else begin
      sh   = s3_lzc - LZ_W'(1);
      norm = s3_sum << sh;
    end
    e_n = E_W'(s3_e) + E_W'(carry) - E_W'(sh);
    inc = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[S_W-2:3]} + {{M_W{1'b0}}, inc};
    e_r = rnd[M_W] ? (e_n + E_W'(1)) : e_n;

    r_ab  = {s3_sign, e_r[EXP_W-1:0], rnd[MAN_W-1:0]};
    r_ovf = 1'b0;
    r_unf = 1'b0;
    r_nan = 1'b0;
    if (s3_nan) begin
      r_ab  = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      r_nan = 1'b1;
    end else if (s3_inf) begin
      r_ab = {s3_inf_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s3_sum == '0) begin
      r_ab = {~s3_sub & s3_sign, {(W-1){1'b0}}};
    end else if (!e_r[E_W-1] && (e_r >= E_W'(EXP_ONES))) begin
      r_ab  = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
      r_ovf = 1'b1;
    end else if (e_r[E_W-1] || (e_r == '0)) begin
      r_ab  = {s3_sign, {(W-1){1'b0}}};
      r_unf = 1'b1;
    end
  end

  assign unused_bits = norm[S_W-1] ^ rnd[MAN_W];

  // Output register; data holds between valid results
  always_ff @(negedge MAIN_CLK or posedge MAIN_RST) begin
    if (MAIN_RST) begin
      out_valid <= 1'b0;
      ab        <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      nan       <= 1'b0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        ab  <= r_ab;
        ovf <= r_ovf;
        unf <= r_unf;
        nan <= r_nan;
      end
    end
  end

endmodule
